response_checker: RTL and testbench
===================================

RESPONSE_CHECKER -- requirements
Module: response_checker

Interface
REQ-001 Parameter: LATENCY, default 4, DUT pipeline depth in cycles from vector apply to valid output; legal range 1..16.
REQ-002 Parameter: OUT_W, default 1, width of DUT output and golden response.
REQ-003 Parameter: CNT_W, default 32, width of error counter.
REQ-004 Port: clk  in  1  single clock; all logic on rising edge.
REQ-005 Port: rst  in  1  synchronous reset, active-high.
REQ-006 Port: start  in  1  one-cycle pulse; opens a test run.
REQ-007 Port: vec_valid  in  1  golden word on golden is applied to DUT this cycle.
REQ-008 Port: vec_last  in  1  qualifies vec_valid; marks final vector of run.
REQ-009 Port: golden  in  OUT_W  expected DUT response for vector applied this cycle.
REQ-010 Port: dut_out  in  OUT_W  DUT output, sampled every rising edge.
REQ-011 Port: busy  out  1  high in RUN or DRAIN.
REQ-012 Port: done  out  1  high in DONE; held until start or rst.
REQ-013 Port: err_count  out  CNT_W  number of mismatching compare cycles in current/last run.
REQ-014 Port: err_sat  out  1  sticky; err_count reached all-ones.
REQ-015 Port: mismatch  out  1  registered one-cycle flag; a compare failed on previous edge.

Function
REQ-016 FSM states IDLE, RUN, DRAIN, DONE; encoding free.
REQ-017 IDLE->RUN on start; DONE->RUN on start; start ignored in RUN and DRAIN.
REQ-018 Entering RUN clears err_count, err_sat, mismatch, drain counter and all delay-line valid tags in the same edge.
REQ-019 Delay line: LATENCY stages of {valid, golden}; shifts every cycle in RUN and DRAIN regardless of vec_valid.
REQ-020 Stage-0 load in RUN: valid=vec_valid, golden=golden; in IDLE, DRAIN, DONE: valid=0.
REQ-021 vec_valid and vec_last in IDLE or DONE, including the start cycle, are ignored; first accepted vector is the cycle after start.
REQ-022 Compare: at each edge in RUN or DRAIN where tail stage valid=1, dut_out is compared with tail golden; vector applied at edge t is compared at edge t+LATENCY.
REQ-023 Mismatch = any of OUT_W bits differ; one increment per mismatching cycle, not per bit.
REQ-024 err_count saturates at 2^CNT_W-1; err_sat sets on the increment that reaches all-ones and holds; further mismatches leave err_count unchanged.
REQ-025 mismatch is high the cycle after a failing compare, else low; cleared in IDLE/DONE.
REQ-026 RUN->DRAIN on edge where vec_valid=1 and vec_last=1; vec_last with vec_valid=0 has no effect.
REQ-027 DRAIN lasts exactly LATENCY cycles, comparing remaining in-flight vectors; then DRAIN->DONE.
REQ-028 err_count, err_sat stable in DONE until next start; done=1, busy=0 in DONE.
REQ-029 Tail entries with valid=0 (gaps, flushed slots) are never compared, whatever dut_out holds.
REQ-030 Latency start->busy: 1 cycle; last vector->done: LATENCY+1 cycles.

Reset
REQ-031 rst=1 at an edge forces IDLE, clears delay-line valid tags, err_count=0, err_sat=0, mismatch=0, done=0, busy=0; golden payload need not reset.
REQ-032 rst dominates start and all other inputs in the same cycle.
REQ-033 rst in RUN or DRAIN aborts the run; no compare occurs at the reset edge or after it until the next start.

Verification
REQ-034 LATENCY=4: start, 10 vectors all matching dut_out delayed by 4, last flagged -> done 5 cycles after last vector, err_count=0, mismatch never high.
REQ-035 LATENCY=4: 8 vectors, dut_out corrupted at compare slots of vectors 2 and 7 -> err_count=2, two mismatch pulses 1 cycle after those compares.
REQ-036 vec_valid low for 3 cycles mid-run with dut_out toggling randomly during the corresponding compare slots -> those slots not counted, err_count=0.
REQ-037 CNT_W=3, every compare fails for 10 vectors -> err_count=7, err_sat=1 after 7th failure, remains 7.
REQ-038 rst asserted 2 cycles into DRAIN with 2 failures pending in delay line -> busy=0, done=0, err_count=0 next cycle, no further increments.
REQ-039 start while busy and vec_last with vec_valid=0 -> both ignored; run ends only on valid last vector; second start from DONE clears err_count to 0.

Source files
------------

// File: rtl/response_checker.sv
// Response checker: delays golden words by LATENCY cycles and
// compares them against the DUT output, counting mismatching cycles.
module response_checker #(
  parameter int LATENCY = 4,
  parameter int OUT_W   = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  input  logic             vec_last,
  input  logic [OUT_W-1:0] golden,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic             err_sat,
  output logic             mismatch
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [4:0]       DLAST = 5'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CMAX  = '1;
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t           state;
  logic [LATENCY-1:0] vld;
  logic [OUT_W-1:0] gld [LATENCY];
  logic [4:0]       dcnt;
  logic             active;
  logic             fail;
  logic [CNT_W-1:0] err_nxt;

  assign active  = (state == RUN) || (state == DRAIN);
  assign fail    = active && vld[LATENCY-1] &&
                   (dut_out != gld[LATENCY-1]);
  assign err_nxt = err_count + ONE;

  // Payload needs no reset: only the valid tags decide what is compared.
  always_ff @(posedge clk) begin
    gld[0] <= golden;
    for (int i = 1; i < LATENCY; i++)
      gld[i] <= gld[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vld       <= '0;
      dcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_count <= '0;
      err_sat   <= 1'b0;
      mismatch  <= 1'b0;
    end else begin
      mismatch <= fail;
      if (fail && (err_count != CMAX)) begin
        err_count <= err_nxt;
        if (err_nxt == CMAX)
          err_sat <= 1'b1;
      end
      vld[0] <= (state == RUN) && vec_valid;
      for (int i = 1; i < LATENCY; i++)
        vld[i] <= vld[i-1];
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            vld       <= '0;
            dcnt      <= '0;
            err_count <= '0;
            err_sat   <= 1'b0;
            mismatch  <= 1'b0;
          end
        end
        RUN: begin
          if (vec_valid && vec_last) begin
            state <= DRAIN;
            dcnt  <= '0;
          end
        end
        DRAIN: begin
          if (dcnt == DLAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            dcnt <= dcnt + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_response_checker.sv
// Directed bench for response_checker (LATENCY=4, OUT_W=4);
// a second instance with CNT_W=3 shares the stimulus for saturation.
module tb_response_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       vec_valid = 1'b0;
  logic       vec_last = 1'b0;
  logic [3:0] golden = '0;
  logic [3:0] dut_out = '0;

  logic        busy, done, err_sat, mismatch;
  logic [31:0] err_count;
  logic        busy3, done3, err_sat3, mismatch3;
  logic [2:0]  err_count3;

  int n_tests = 0;
  int n_fail  = 0;
  int n = 0;
  int first_done = -1;
  int first_sat = -1;
  int mm_q[$];
  logic [3:0] gp [4];
  logic [3:0] cp [4];

  always #5 clk = ~clk;

  response_checker #(.LATENCY(4), .OUT_W(4), .CNT_W(32)) u0 (
    .clk(clk), .rst(rst), .start(start),
    .vec_valid(vec_valid), .vec_last(vec_last),
    .golden(golden), .dut_out(dut_out),
    .busy(busy), .done(done), .err_count(err_count),
    .err_sat(err_sat), .mismatch(mismatch)
  );

  response_checker #(.LATENCY(4), .OUT_W(4), .CNT_W(3)) u1 (
    .clk(clk), .rst(rst), .start(start),
    .vec_valid(vec_valid), .vec_last(vec_last),
    .golden(golden), .dut_out(dut_out),
    .busy(busy3), .done(done3), .err_count(err_count3),
    .err_sat(err_sat3), .mismatch(mismatch3)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // dut_out replays each golden word 4 cycles later, xor'd with its mask.
  task automatic cyc(input logic st, input logic v, input logic last,
                     input logic [3:0] g, input logic [3:0] c);
    start     = st;
    vec_valid = v;
    vec_last  = last;
    golden    = g;
    dut_out   = gp[3] ^ cp[3];
    for (int i = 3; i > 0; i--) begin
      gp[i] = gp[i-1];
      cp[i] = cp[i-1];
    end
    gp[0] = g;
    cp[0] = c;
    @(posedge clk);
    #1;
    if (mismatch) mm_q.push_back(n);
    if (done && first_done < 0) first_done = n;
    if (err_sat3 && first_sat < 0) first_sat = n;
    n++;
  endtask

  task automatic begin_run();
    n = 0;
    mm_q.delete();
    first_done = -1;
    first_sat = -1;
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++)
      cyc(1'b0, 1'b0, 1'b0, 4'($urandom), 4'h0);
  endtask

  function automatic logic [3:0] gv(input int i);
    return 4'(i * 5 + 3);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      gp[i] = '0;
      cp[i] = '0;
    end
    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 4'h0, 4'h0);
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cnt", err_count, 0);
    chk("rst_sat", 32'(err_sat), 0);
    chk("rst_mm", 32'(mismatch), 0);
    rst = 1'b0;
    idle(2);
    chk("idle_busy", 32'(busy), 0);

    // all vectors match
    begin_run();
    chk("t1_busy", 32'(busy), 1);
    for (int i = 1; i <= 10; i++)
      cyc(1'b0, 1'b1, i == 10, gv(i), 4'h0);
    idle(6);
    chk("t1_done_at", 32'(first_done), 14);
    chk("t1_cnt", err_count, 0);
    chk("t1_mm_n", 32'(mm_q.size()), 0);
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_done_hold", 32'(done), 1);

    // vectors 2 and 7 corrupted (2 is multi-bit)
    begin_run();
    chk("t2_done_clr", 32'(done), 0);
    for (int i = 1; i <= 8; i++)
      cyc(1'b0, 1'b1, i == 8, gv(i),
          (i == 2) ? 4'b0011 : (i == 7) ? 4'b1000 : 4'h0);
    idle(6);
    chk("t2_cnt", err_count, 2);
    chk("t2_mm_n", 32'(mm_q.size()), 2);
    if (mm_q.size() == 2) begin
      chk("t2_mm0_at", 32'(mm_q[0]), 6);
      chk("t2_mm1_at", 32'(mm_q[1]), 11);
    end
    chk("t2_done_at", 32'(first_done), 12);
    chk("t2_mm_low", 32'(mismatch), 0);

    // gaps with random dut_out in their slots
    begin_run();
    for (int i = 1; i <= 3; i++)
      cyc(1'b0, 1'b1, 1'b0, gv(i), 4'h0);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 1'b0, 4'($urandom), 4'($urandom) | 4'h1);
    for (int i = 4; i <= 6; i++)
      cyc(1'b0, 1'b1, i == 6, gv(i), 4'h0);
    idle(6);
    chk("t3_cnt", err_count, 0);
    chk("t3_mm_n", 32'(mm_q.size()), 0);
    chk("t3_done_at", 32'(first_done), 13);

    // every compare fails; 3-bit counter saturates
    begin_run();
    for (int i = 1; i <= 10; i++)
      cyc(1'b0, 1'b1, i == 10, gv(i), 4'b0001);
    idle(6);
    chk("t4_cnt3", 32'(err_count3), 7);
    chk("t4_sat3", 32'(err_sat3), 1);
    chk("t4_sat_at", 32'(first_sat), 11);
    chk("t4_cnt32", err_count, 10);
    chk("t4_sat32", 32'(err_sat), 0);
    chk("t4_mm_n", 32'(mm_q.size()), 10);

    // reset two cycles into drain with failures pending
    begin_run();
    for (int i = 1; i <= 6; i++)
      cyc(1'b0, 1'b1, i == 6, gv(i), (i >= 5) ? 4'b0100 : 4'h0);
    idle(1);
    chk("t5_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 4'h0, 4'h0);
    rst = 1'b0;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_done", 32'(done), 0);
    chk("t5_cnt", err_count, 0);
    idle(6);
    chk("t5_cnt_end", err_count, 0);
    chk("t5_mm_n", 32'(mm_q.size()), 0);
    chk("t5_done_end", 32'(done), 0);

    // start while busy and unqualified vec_last are ignored
    begin_run();
    cyc(1'b0, 1'b1, 1'b0, gv(1), 4'b0010);
    cyc(1'b0, 1'b1, 1'b0, gv(2), 4'h0);
    cyc(1'b0, 1'b0, 1'b1, gv(9), 4'h0);
    cyc(1'b0, 1'b1, 1'b0, gv(3), 4'h0);
    cyc(1'b0, 1'b1, 1'b0, gv(4), 4'h0);
    cyc(1'b1, 1'b1, 1'b0, gv(5), 4'h0);
    cyc(1'b0, 1'b1, 1'b1, gv(6), 4'h0);
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    idle(4);
    chk("t6_done_at", 32'(first_done), 11);
    chk("t6_cnt", err_count, 1);
    chk("t6_mm_n", 32'(mm_q.size()), 1);
    begin_run();
    chk("t6_restart_cnt", err_count, 0);
    chk("t6_restart_busy", 32'(busy), 1);
    chk("t6_restart_done", 32'(done), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
